// File: rtl/uart_ctrl_regfile_if.sv
// Register-bus interface for uart_ctrl_regfile: write/read strobes,
// {channel, offset} address, write data, and registered read return.
interface uart_ctrl_regfile_if #(
  parameter int ADDR_W = 5
) ();
  logic              p_We_i;
  logic              p_Re_i;
  logic [ADDR_W-1:0] Addr_i;
  logic [15:0]       Data_i;
  logic [15:0]       Data_o;
  logic              p_RdValid_o;

  modport master (
    output p_We_i, p_Re_i, Addr_i, Data_i,
    input  Data_o, p_RdValid_o
  );

  modport slave (
    input  p_We_i, p_Re_i, Addr_i, Data_i,
    output Data_o, p_RdValid_o
  );
endinterface

// File: rtl/uart_ctrl_regfile.sv
// Multi-channel UART configuration/status register file.
// Frame-shaping registers (ModeCtrl, BaudRateGen, BitCompensate) are written
// into a shadow copy and promoted to the active copy only while the channel
// is idle, so a frame in flight never sees its configuration change.
// Interrupt and trigger registers act immediately.
module uart_ctrl_regfile #(
  parameter int          NCH               = 2,
  parameter int          CH_W              = 1,
  parameter logic [15:0] DEFAULT_PERIOD    = 16'd20,
  parameter logic [3:0]  DEFAULT_UP_TIME   = 4'd10,
  parameter logic [3:0]  DEFAULT_DOWN_TIME = 4'd5
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_ctrl_regfile_if.slave   bus,
  input  logic [NCH-1:0]       p_Busy_i,
  input  logic [16*NCH-1:0]    IntEvent_i,
  input  logic [16*NCH-1:0]    UartState_i,
  output logic [8*NCH-1:0]     ModeCtrl_o,
  output logic [16*NCH-1:0]    BaudRateGen_o,
  output logic [8*NCH-1:0]     BitCompensate_o,
  output logic [5*NCH-1:0]     AcqNumPerBit_o,
  output logic [16*NCH-1:0]    RxTrig_o,
  output logic [16*NCH-1:0]    TxTrig_o,
  output logic [NCH-1:0]       p_ParityEnable_o,
  output logic [NCH-1:0]       p_BigEnd_o,
  output logic [NCH-1:0]       ParityMethod_o,
  output logic [NCH-1:0]       p_Irq_o
);

  localparam logic [7:0] MODE_RST = 8'b0100_0001;
  localparam logic [4:0] ACQ_RST  = {1'b0, DEFAULT_UP_TIME} + {1'b0, DEFAULT_DOWN_TIME};

  localparam logic [3:0] OFF_MODE   = 4'd0;
  localparam logic [3:0] OFF_BAUD   = 4'd1;
  localparam logic [3:0] OFF_COMP   = 4'd2;
  localparam logic [3:0] OFF_INTEN  = 4'd3;
  localparam logic [3:0] OFF_INTMSK = 4'd4;
  localparam logic [3:0] OFF_INTST  = 4'd5;
  localparam logic [3:0] OFF_RXTRIG = 4'd6;
  localparam logic [3:0] OFF_TXTRIG = 4'd7;
  localparam logic [3:0] OFF_STATE  = 4'd8;

  logic [CH_W-1:0]     chSel;
  logic [3:0]          offSel;
  logic                chValid;
  logic                compWrOk;
  logic [16*NCH-1:0]   chanRd;
  logic [15:0]         rdMux;

  assign chSel  = bus.Addr_i[CH_W+3:4];
  assign offSel = bus.Addr_i[3:0];

  // A BitCompensate write with a zero nibble sum would give zero samples per bit.
  assign compWrOk = ({1'b0, bus.Data_i[7:4]} + {1'b0, bus.Data_i[3:0]}) != 5'd0;

  // Channel codes beyond NCH exist only when the select field is not fully used.
  generate
    if ((1 << CH_W) > NCH) begin : genChRange
      assign chValid = chSel < CH_W'(NCH);
    end else begin : genChAll
      assign chValid = 1'b1;
    end
  endgenerate

  generate
    for (genvar c = 0; c < NCH; c++) begin : genChan
      logic        wrThis;
      logic        shadowWr;
      logic        applyNow;
      logic        pend;
      logic [7:0]  modeSh, modeAct;
      logic [15:0] baudSh, baudAct;
      logic [7:0]  compSh, compAct;
      logic [4:0]  acq;
      logic [15:0] intEn, intMask, intState, rxTrig, txTrig;
      logic [15:0] w1cMask;
      logic        irq;
      logic [15:0] rdVal;
      logic        unusedState;

      assign wrThis   = bus.p_We_i && chValid && (chSel == CH_W'(c));
      assign shadowWr = wrThis && ((offSel == OFF_MODE) || (offSel == OFF_BAUD) ||
                                   ((offSel == OFF_COMP) && compWrOk));
      assign applyNow = pend && !p_Busy_i[c];
      assign w1cMask  = (wrThis && (offSel == OFF_INTST)) ? bus.Data_i : 16'h0000;
      assign unusedState = UartState_i[16*c+15];

      // Shadow capture, idle-time promotion to the active copy, pending flag.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          modeSh  <= MODE_RST;
          modeAct <= MODE_RST;
          baudSh  <= DEFAULT_PERIOD;
          baudAct <= DEFAULT_PERIOD;
          compSh  <= {DEFAULT_UP_TIME, DEFAULT_DOWN_TIME};
          compAct <= {DEFAULT_UP_TIME, DEFAULT_DOWN_TIME};
          acq     <= ACQ_RST;
          pend    <= 1'b0;
        end else begin
          if (applyNow) begin
            modeAct <= modeSh;
            baudAct <= baudSh;
            compAct <= compSh;
            acq     <= {1'b0, compSh[7:4]} + {1'b0, compSh[3:0]};
          end
          if (wrThis && (offSel == OFF_MODE)) modeSh <= bus.Data_i[7:0];
          if (wrThis && (offSel == OFF_BAUD)) baudSh <= bus.Data_i;
          if (wrThis && (offSel == OFF_COMP) && compWrOk) compSh <= bus.Data_i[7:0];
          // A write landing on the apply edge keeps pending so it is promoted next.
          if (shadowWr)      pend <= 1'b1;
          else if (applyNow) pend <= 1'b0;
        end
      end

      // Unshadowed control registers, effective on the edge after the write.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          intEn   <= 16'h0000;
          intMask <= 16'hFFFF;
          rxTrig  <= 16'd8;
          txTrig  <= 16'd8;
        end else if (wrThis) begin
          if (offSel == OFF_INTEN)  intEn   <= bus.Data_i;
          if (offSel == OFF_INTMSK) intMask <= bus.Data_i;
          if (offSel == OFF_RXTRIG) rxTrig  <= bus.Data_i;
          if (offSel == OFF_TXTRIG) txTrig  <= bus.Data_i;
        end
      end

      // Sticky interrupt status; a new event beats a simultaneous clear.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) intState <= 16'h0000;
        else      intState <= (intState & ~w1cMask) | IntEvent_i[16*c +: 16];
      end

      // Registered interrupt request from enabled, unmasked status bits.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= |(intState & intEn & ~intMask);
      end

      // Per-channel read value; offset 8 reports pending in bit 15.
      always_comb begin
        rdVal = 16'h0000;
        case (offSel)
          OFF_MODE:   rdVal = {8'h00, modeSh};
          OFF_BAUD:   rdVal = baudSh;
          OFF_COMP:   rdVal = {8'h00, compSh};
          OFF_INTEN:  rdVal = intEn;
          OFF_INTMSK: rdVal = intMask;
          OFF_INTST:  rdVal = intState;
          OFF_RXTRIG: rdVal = rxTrig;
          OFF_TXTRIG: rdVal = txTrig;
          OFF_STATE:  rdVal = {pend, UartState_i[16*c +: 15]};
          default:    rdVal = 16'h0000;
        endcase
      end

      assign chanRd[16*c +: 16]          = rdVal;
      assign ModeCtrl_o[8*c +: 8]        = modeAct;
      assign BaudRateGen_o[16*c +: 16]   = baudAct;
      assign BitCompensate_o[8*c +: 8]   = compAct;
      assign AcqNumPerBit_o[5*c +: 5]    = acq;
      assign RxTrig_o[16*c +: 16]        = rxTrig;
      assign TxTrig_o[16*c +: 16]        = txTrig;
      assign p_ParityEnable_o[c]         = modeAct[6];
      assign p_BigEnd_o[c]               = modeAct[7];
      assign ParityMethod_o[c]           = modeAct[5];
      assign p_Irq_o[c]                  = irq;
    end
  endgenerate

  // Channel select for the read path; unknown channels read as zero.
  always_comb begin
    rdMux = 16'h0000;
    for (int c = 0; c < NCH; c++) begin
      if (chValid && (chSel == CH_W'(c))) rdMux = chanRd[16*c +: 16];
    end
  end

  // One-cycle read return; Data_o holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.Data_o      <= 16'h0000;
      bus.p_RdValid_o <= 1'b0;
    end else if (bus.p_Re_i) begin
      bus.Data_o      <= rdMux;
      bus.p_RdValid_o <= 1'b1;
    end else begin
      bus.p_RdValid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_ctrl_regfile.sv
// Directed bench for uart_ctrl_regfile: a default 2-channel instance plus a
// 3-channel instance for the unused-channel-code and reset-while-pending cases.
module tb_uart_ctrl_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 2-channel instance ----------------
  uart_ctrl_regfile_if #(.ADDR_W(5)) bus0 ();
  logic [1:0]  busy0;
  logic [31:0] evt0, state0;
  logic [15:0] mode0, comp0;
  logic [31:0] baud0, rx0, tx0;
  logic [9:0]  acq0;
  logic [1:0]  pe0, be0, pm0, irq0;

  uart_ctrl_regfile #(.NCH(2), .CH_W(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .p_Busy_i(busy0), .IntEvent_i(evt0), .UartState_i(state0),
    .ModeCtrl_o(mode0), .BaudRateGen_o(baud0), .BitCompensate_o(comp0),
    .AcqNumPerBit_o(acq0), .RxTrig_o(rx0), .TxTrig_o(tx0),
    .p_ParityEnable_o(pe0), .p_BigEnd_o(be0), .ParityMethod_o(pm0),
    .p_Irq_o(irq0)
  );

  // ---------------- 3-channel instance ----------------
  uart_ctrl_regfile_if #(.ADDR_W(6)) bus2 ();
  logic [2:0]  busy2;
  logic [47:0] evt2, state2;
  logic [23:0] mode2, comp2;
  logic [47:0] baud2, rx2, tx2;
  logic [14:0] acq2;
  logic [2:0]  pe2, be2, pm2, irq2;

  uart_ctrl_regfile #(.NCH(3), .CH_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .p_Busy_i(busy2), .IntEvent_i(evt2), .UartState_i(state2),
    .ModeCtrl_o(mode2), .BaudRateGen_o(baud2), .BitCompensate_o(comp2),
    .AcqNumPerBit_o(acq2), .RxTrig_o(rx2), .TxTrig_o(tx2),
    .p_ParityEnable_o(pe2), .p_BigEnd_o(be2), .ParityMethod_o(pm2),
    .p_Irq_o(irq2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wr0(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bus0.p_We_i = 1'b1; bus0.Addr_i = a; bus0.Data_i = d;
    @(negedge clk);
    bus0.p_We_i = 1'b0;
  endtask

  task automatic rd0(input logic [4:0] a, output logic [15:0] d, output logic v);
    @(negedge clk);
    bus0.p_Re_i = 1'b1; bus0.Addr_i = a;
    @(posedge clk);
    #1;
    d = bus0.Data_o; v = bus0.p_RdValid_o;
    @(negedge clk);
    bus0.p_Re_i = 1'b0;
  endtask

  task automatic wr2(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    bus2.p_We_i = 1'b1; bus2.Addr_i = a; bus2.Data_i = d;
    @(negedge clk);
    bus2.p_We_i = 1'b0;
  endtask

  task automatic rd2(input logic [5:0] a, output logic [15:0] d, output logic v);
    @(negedge clk);
    bus2.p_Re_i = 1'b1; bus2.Addr_i = a;
    @(posedge clk);
    #1;
    d = bus2.Data_o; v = bus2.p_RdValid_o;
    @(negedge clk);
    bus2.p_Re_i = 1'b0;
  endtask

  typedef struct {
    logic        doWr;
    logic [4:0]  wAddr;
    logic [15:0] wData;
    logic [4:0]  rAddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] rdData;
    logic        rdV;

    // UartState ch1=8456, ch0=7123
    vecs[0]  = '{1'b0, 5'h00, 16'h0000, 5'h00, 16'h0041};
    vecs[1]  = '{1'b0, 5'h00, 16'h0000, 5'h01, 16'h0014};
    vecs[2]  = '{1'b0, 5'h00, 16'h0000, 5'h12, 16'h00A5};
    vecs[3]  = '{1'b0, 5'h00, 16'h0000, 5'h03, 16'h0000};
    vecs[4]  = '{1'b0, 5'h00, 16'h0000, 5'h04, 16'hFFFF};
    vecs[5]  = '{1'b0, 5'h00, 16'h0000, 5'h16, 16'h0008};
    vecs[6]  = '{1'b0, 5'h00, 16'h0000, 5'h17, 16'h0008};
    vecs[7]  = '{1'b0, 5'h00, 16'h0000, 5'h0C, 16'h0000};
    vecs[8]  = '{1'b0, 5'h00, 16'h0000, 5'h08, 16'h7123};
    vecs[9]  = '{1'b0, 5'h00, 16'h0000, 5'h18, 16'h0456};
    vecs[10] = '{1'b1, 5'h16, 16'h1234, 5'h16, 16'h1234};
    vecs[11] = '{1'b1, 5'h00, 16'hABC3, 5'h00, 16'h00C3};
    vecs[12] = '{1'b1, 5'h08, 16'hFFFF, 5'h08, 16'h7123};
    vecs[13] = '{1'b1, 5'h0D, 16'hFFFF, 5'h0D, 16'h0000};
    vecs[14] = '{1'b1, 5'h14, 16'h00F0, 5'h14, 16'h00F0};
    vecs[15] = '{1'b1, 5'h11, 16'h0303, 5'h11, 16'h0303};

    rst = 1'b0;
    bus0.p_We_i = 1'b0; bus0.p_Re_i = 1'b0; bus0.Addr_i = '0; bus0.Data_i = '0;
    bus2.p_We_i = 1'b0; bus2.p_Re_i = 1'b0; bus2.Addr_i = '0; bus2.Data_i = '0;
    busy0 = '0; evt0 = '0; state0 = {16'h8456, 16'h7123};
    busy2 = '0; evt2 = '0; state2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_mode",  64'(mode0), 64'h4141);
    chk("rst_baud",  64'(baud0), 64'h0014_0014);
    chk("rst_comp",  64'(comp0), 64'hA5A5);
    chk("rst_acq",   64'(acq0),  64'({5'd15, 5'd15}));
    chk("rst_rxtx",  64'({rx0, tx0}), 64'h0008_0008_0008_0008);
    chk("rst_dec",   64'({pe0, be0, pm0}), 64'b11_00_00);
    chk("rst_irq",   64'(irq0), 64'h0);
    chk("rst_rd",    64'({bus0.p_RdValid_o, bus0.Data_o}), 64'h0);
    chk("rst_mode2", 64'(mode2), 64'h41_4141);

    // Table-driven register access
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].doWr) wr0(vecs[i].wAddr, vecs[i].wData);
      rd0(vecs[i].rAddr, rdData, rdV);
      chk($sformatf("vec%0d_data", i), 64'(rdData), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_valid", i), 64'(rdV), 64'h1);
    end
    chk("tbl_mode", 64'(mode0), 64'h41C3);
    chk("tbl_dec",  64'({pe0, be0, pm0}), 64'b11_01_00);
    chk("tbl_baud1", 64'(baud0[31:16]), 64'h0303);
    chk("tbl_rx1",  64'(rx0[31:16]), 64'h1234);

    // Valid drops the cycle after a read, data holds
    @(posedge clk); #1;
    chk("rd_valid_drop", 64'(bus0.p_RdValid_o), 64'h0);
    chk("rd_hold", 64'(bus0.Data_o), 64'h0303);

    // Baud write held off while busy
    @(negedge clk) busy0 = 2'b01;
    wr0(5'h01, 16'd434);
    repeat (10) @(negedge clk);
    chk("busy_baud", 64'(baud0[15:0]), 64'd20);
    rd0(5'h08, rdData, rdV);
    chk("busy_pending", 64'(rdData), 64'hF123);
    @(negedge clk) busy0 = 2'b00;
    #1 chk("busy_drop_pre", 64'(baud0[15:0]), 64'd20);
    @(posedge clk); #1;
    chk("busy_drop_apply", 64'(baud0[15:0]), 64'd434);
    rd0(5'h08, rdData, rdV);
    chk("pending_clr", 64'(rdData), 64'h7123);

    // Nibble sum without truncation; zero-sum write ignored
    wr0(5'h12, 16'h00FF);
    @(negedge clk);
    chk("acq_ff", 64'(acq0[9:5]), 64'd30);
    chk("comp_ff", 64'(comp0[15:8]), 64'hFF);
    wr0(5'h12, 16'h0000);
    repeat (2) @(negedge clk);
    chk("acq_zero_ign", 64'(acq0[9:5]), 64'd30);
    rd0(5'h12, rdData, rdV);
    chk("comp_sh_zero_ign", 64'(rdData), 64'h00FF);

    // Interrupt: set beats simultaneous W1C, then W1C alone
    wr0(5'h03, 16'h0001);
    wr0(5'h04, 16'h0000);
    @(negedge clk);
    bus0.p_We_i = 1'b1; bus0.Addr_i = 5'h05; bus0.Data_i = 16'h0001; evt0 = 32'h1;
    @(posedge clk); #1;
    chk("irq_lag", 64'(irq0), 64'h0);
    @(negedge clk);
    bus0.p_We_i = 1'b0; evt0 = '0;
    @(posedge clk); #1;
    chk("irq_set", 64'(irq0), 64'h1);
    rd0(5'h05, rdData, rdV);
    chk("intst_set", 64'(rdData), 64'h0001);
    wr0(5'h05, 16'h0001);
    @(posedge clk); #1;
    chk("irq_clr", 64'(irq0), 64'h0);
    rd0(5'h05, rdData, rdV);
    chk("intst_clr", 64'(rdData), 64'h0000);
    wr0(5'h04, 16'h0001);
    @(negedge clk) evt0 = 32'h1;
    @(negedge clk) evt0 = '0;
    repeat (2) @(negedge clk);
    chk("irq_masked", 64'(irq0), 64'h0);
    rd0(5'h05, rdData, rdV);
    chk("intst_masked", 64'(rdData), 64'h0001);

    // Shadow write on the apply edge: apply old shadow, keep pending
    @(negedge clk) busy0 = 2'b10;
    wr0(5'h11, 16'd100);
    @(negedge clk);
    busy0 = 2'b00;
    bus0.p_We_i = 1'b1; bus0.Addr_i = 5'h11; bus0.Data_i = 16'd200;
    @(posedge clk); #1;
    chk("coinc_apply_old", 64'(baud0[31:16]), 64'd100);
    @(negedge clk) bus0.p_We_i = 1'b0;
    @(posedge clk); #1;
    chk("coinc_apply_new", 64'(baud0[31:16]), 64'd200);

    // Simultaneous write and read returns pre-write value
    @(negedge clk);
    bus0.p_We_i = 1'b1; bus0.p_Re_i = 1'b1; bus0.Addr_i = 5'h16; bus0.Data_i = 16'h5555;
    @(posedge clk); #1;
    chk("wr_rd_old", 64'({bus0.p_RdValid_o, bus0.Data_o}), 64'h1_1234);
    @(negedge clk);
    bus0.p_We_i = 1'b0; bus0.p_Re_i = 1'b0;
    rd0(5'h16, rdData, rdV);
    chk("wr_rd_new", 64'(rdData), 64'h5555);

    // NCH=3: channel code 3 is unused
    wr2({2'd3, 4'd1}, 16'h1234);
    wr2({2'd3, 4'd0}, 16'h0000);
    wr2({2'd3, 4'd6}, 16'h0077);
    repeat (2) @(negedge clk);
    chk("ch3_baud", 64'(baud2), 64'h0014_0014_0014);
    chk("ch3_mode", 64'(mode2), 64'h41_4141);
    chk("ch3_rx",   64'(rx2),   64'h0008_0008_0008);
    rd2({2'd3, 4'd1}, rdData, rdV);
    chk("ch3_rd", 64'({rdV, rdData}), 64'h1_0000);
    rd2({2'd2, 4'd1}, rdData, rdV);
    chk("ch2_rd", 64'(rdData), 64'h0014);

    // Reset while pending and busy
    @(negedge clk) busy2 = 3'b111;
    wr2({2'd2, 4'd1}, 16'h1111);
    wr2({2'd0, 4'd0}, 16'h0000);
    rd2({2'd2, 4'd8}, rdData, rdV);
    chk("ch2_pending", 64'(rdData), 64'h8000);
    @(negedge clk) rst = 1'b0;
    #2;
    chk("arst_baud2", 64'(baud2), 64'h0014_0014_0014);
    chk("arst_rd0",   64'({bus0.p_RdValid_o, bus0.Data_o}), 64'h0);
    @(negedge clk);
    rst = 1'b1; busy2 = 3'b000;
    repeat (2) @(negedge clk);
    chk("post_rst_baud2", 64'(baud2), 64'h0014_0014_0014);
    chk("post_rst_mode2", 64'(mode2), 64'h41_4141);
    chk("post_rst_pe2",   64'(pe2), 64'h7);
    chk("post_rst_acq2",  64'(acq2), 64'({5'd15, 5'd15, 5'd15}));
    chk("post_rst_mode0", 64'(mode0), 64'h4141);
    chk("post_rst_baud0", 64'(baud0), 64'h0014_0014);
    chk("post_rst_acq0",  64'(acq0), 64'({5'd15, 5'd15}));
    rd2({2'd2, 4'd8}, rdData, rdV);
    chk("post_rst_pend2", 64'(rdData), 64'h0000);
    rd2({2'd2, 4'd1}, rdData, rdV);
    chk("post_rst_sh2", 64'(rdData), 64'h0014);
    rd0(5'h04, rdData, rdV);
    chk("post_rst_mask0", 64'(rdData), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
